// File: rtl/csr_irq_ctrl.sv
// rtl/csr_irq_ctrl.sv - machine-mode CSR file with multi-source fixed-priority interrupt controller
//
// Purpose: holds mstatus/mie/mtvec/mscratch/mepc/mcause/mip. Takes interrupt traps on a
// retiring instruction and handles mret. Trap and return redirects go to the fetch PC mux
// as one-cycle registered pulses.
// Optional feature: define CSR_MCYCLE_EN to add a 64-bit mcycle counter at 0xB00/0xB80.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   ext_irq_i, irq_i[NUM_IRQ]      level interrupt inputs (MEIP, local lines 16+i)
//   instr_valid_i, pc_i            retiring instruction; a trap may be taken on it
//   is_mret_i                      an mret is retiring
//   csr_addr_r_i -> csr_data_o     combinational CSR read port
//   csr_we_i, csr_addr_w_i, csr_data_i   CSR write port
//   trap_taken_o, mret_taken_o     one-cycle redirect pulses
//   trap_pc_o                      redirect target
module csr_irq_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ext_irq_i,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic                  instr_valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  is_mret_i,
    input  logic [11:0]           csr_addr_r_i,
    output logic [DATA_WIDTH-1:0] csr_data_o,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_addr_w_i,
    input  logic [DATA_WIDTH-1:0] csr_data_i,
    output logic                  trap_taken_o,
    output logic                  mret_taken_o,
    output logic [31:0]           trap_pc_o
);

    localparam logic [31:0] IRQ_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
    localparam logic [31:0] MIE_MASK = IRQ_MASK | 32'h0000_0800;

    typedef enum logic [1:0] {S_RUN, S_TAKE, S_RET} state_t;

    state_t      state_q, state_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mie_q, mie_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [29:0] tvec_base_q, tvec_base_d;
    logic        tvec_vec_q, tvec_vec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        trap_taken_q, trap_taken_d;
    logic        mret_taken_q, mret_taken_d;
    logic [31:0] trap_pc_q, trap_pc_d;
`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;
`endif

    logic [31:0] pend;
    logic [4:0]  irq_code;
    logic        req;
    logic [31:0] trap_target;

    always_comb begin
        mip_d              = '0;
        mip_d[11]          = ext_irq_i;
        mip_d[16+:NUM_IRQ] = irq_i;
    end

    // Fixed priority: MEIP first, then the lowest-numbered local line.
    // Scanning downward lets the lowest pending line overwrite higher ones.
    always_comb begin
        pend     = mip_q & mie_q;
        irq_code = 5'd11;
        if (!pend[11]) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (pend[16+i]) irq_code = 5'(16 + i);
            end
        end
    end

    assign req         = (|pend) & st_mie_q;
    assign trap_target = {tvec_base_q, 2'b00} +
                         (tvec_vec_q ? {25'd0, irq_code, 2'b00} : 32'd0);

    always_comb begin
        state_d      = state_q;
        mie_d        = mie_q;
        st_mie_d     = st_mie_q;
        st_mpie_d    = st_mpie_q;
        tvec_base_d  = tvec_base_q;
        tvec_vec_d   = tvec_vec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        trap_taken_d = 1'b0;
        mret_taken_d = 1'b0;
        trap_pc_d    = trap_pc_q;
`ifdef CSR_MCYCLE_EN
        mcycle_d     = mcycle_q + 64'd1;
`endif

        // Software writes first; the FSM below overrides mstatus/mepc/mcause
        // when it updates them in the same cycle.
        if (csr_we_i) begin
            case (csr_addr_w_i)
                12'h300: begin
                    st_mie_d  = csr_data_i[3];
                    st_mpie_d = csr_data_i[7];
                end
                12'h304: mie_d = csr_data_i & MIE_MASK;
                12'h305: begin
                    tvec_base_d = csr_data_i[31:2];
                    tvec_vec_d  = (csr_data_i[1:0] == 2'b01);
                end
                12'h340: mscratch_d = csr_data_i;
                12'h341: mepc_d     = csr_data_i & 32'hFFFF_FFFC;
                12'h342: mcause_d   = csr_data_i;
`ifdef CSR_MCYCLE_EN
                // A write freezes the whole counter for that cycle.
                12'hB00: mcycle_d = {mcycle_q[63:32], csr_data_i};
                12'hB80: mcycle_d = {csr_data_i, mcycle_q[31:0]};
`endif
                default: ;
            endcase
        end

        case (state_q)
            S_RUN: begin
                if (req && instr_valid_i) begin
                    mepc_d       = pc_i & 32'hFFFF_FFFC;
                    mcause_d     = {1'b1, 26'd0, irq_code};
                    st_mpie_d    = st_mie_q;
                    st_mie_d     = 1'b0;
                    trap_taken_d = 1'b1;
                    trap_pc_d    = trap_target;
                    state_d      = S_TAKE;
                end else if (is_mret_i) begin
                    st_mie_d     = st_mpie_q;
                    st_mpie_d    = 1'b1;
                    mret_taken_d = 1'b1;
                    trap_pc_d    = mepc_q;
                    state_d      = S_RET;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_RUN;
            mip_q        <= '0;
            mie_q        <= '0;
            st_mie_q     <= 1'b0;
            st_mpie_q    <= 1'b0;
            tvec_base_q  <= RESET_VEC[31:2];
            tvec_vec_q   <= (RESET_VEC[1:0] == 2'b01);
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            trap_taken_q <= 1'b0;
            mret_taken_q <= 1'b0;
            trap_pc_q    <= '0;
`ifdef CSR_MCYCLE_EN
            mcycle_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mip_q        <= mip_d;
            mie_q        <= mie_d;
            st_mie_q     <= st_mie_d;
            st_mpie_q    <= st_mpie_d;
            tvec_base_q  <= tvec_base_d;
            tvec_vec_q   <= tvec_vec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            trap_taken_q <= trap_taken_d;
            mret_taken_q <= mret_taken_d;
            trap_pc_q    <= trap_pc_d;
`ifdef CSR_MCYCLE_EN
            mcycle_q     <= mcycle_d;
`endif
        end
    end

    always_comb begin
        csr_data_o = '0;
        case (csr_addr_r_i)
            12'h300: csr_data_o = {24'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
            12'h304: csr_data_o = mie_q;
            12'h305: csr_data_o = {tvec_base_q, 1'b0, tvec_vec_q};
            12'h340: csr_data_o = mscratch_q;
            12'h341: csr_data_o = mepc_q;
            12'h342: csr_data_o = mcause_q;
            12'h344: csr_data_o = mip_q;
`ifdef CSR_MCYCLE_EN
            12'hB00: csr_data_o = mcycle_q[31:0];
            12'hB80: csr_data_o = mcycle_q[63:32];
`endif
            default: csr_data_o = '0;
        endcase
    end

    assign trap_taken_o = trap_taken_q;
    assign mret_taken_o = mret_taken_q;
    assign trap_pc_o    = trap_pc_q;

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// tb/tb_csr_irq_ctrl.sv - directed self-checking bench for csr_irq_ctrl
module tb_csr_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ext_irq_i = 1'b0;
    logic [3:0]  irq_i = '0;
    logic        instr_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        is_mret_i = 1'b0;
    logic [11:0] csr_addr_r_i = '0;
    logic [31:0] csr_data_o;
    logic        csr_we_i = 1'b0;
    logic [11:0] csr_addr_w_i = '0;
    logic [31:0] csr_data_i = '0;
    logic        trap_taken_o;
    logic        mret_taken_o;
    logic [31:0] trap_pc_o;

    int passed = 0;
    int total  = 0;
    int pulses;

    csr_irq_ctrl #(.DATA_WIDTH(32), .NUM_IRQ(4), .RESET_VEC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ext_irq_i(ext_irq_i), .irq_i(irq_i),
        .instr_valid_i(instr_valid_i), .pc_i(pc_i), .is_mret_i(is_mret_i),
        .csr_addr_r_i(csr_addr_r_i), .csr_data_o(csr_data_o),
        .csr_we_i(csr_we_i), .csr_addr_w_i(csr_addr_w_i), .csr_data_i(csr_data_i),
        .trap_taken_o(trap_taken_o), .mret_taken_o(mret_taken_o), .trap_pc_o(trap_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr_r_i = addr;
        #1;
        chk(tag, csr_data_o, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_we_i     = 1'b1;
        csr_addr_w_i = addr;
        csr_data_i   = data;
        step();
        csr_we_i     = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);
        chk("rst_trap", {31'd0, trap_taken_o}, 32'h0);
        chk("rst_mret", {31'd0, mret_taken_o}, 32'h0);
        chk("rst_trap_pc", trap_pc_o, 32'h0);

        // Plain CSR behaviour
        wr(12'h305, 32'h0000_0202);
        rd("mtvec_mode2", 12'h305, 32'h0000_0200);
        wr(12'h341, 32'h0000_0123);
        rd("mepc_align", 12'h341, 32'h0000_0120);
        wr(12'h340, 32'hDEAD_BEEF);
        rd("mscratch", 12'h340, 32'hDEAD_BEEF);
        wr(12'h342, 32'h1234_5678);
        rd("mcause_rw", 12'h342, 32'h1234_5678);
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_ro", 12'h344, 32'h0);
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd("unmapped", 12'h7C0, 32'h0);
        wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h000F_0800);
        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_mask", 12'h300, 32'h0000_0088);

        // Direct trap
        wr(12'h305, 32'h0000_0100);
        wr(12'h304, 32'h0000_0800);
        wr(12'h300, 32'h0000_0008);
        ext_irq_i = 1'b1;
        step();
        rd("mip_ext", 12'h344, 32'h0000_0800);
        instr_valid_i = 1'b1;
        pc_i = 32'h40;
        step();
        instr_valid_i = 1'b0;
        chk("dir_trap_pulse", {31'd0, trap_taken_o}, 32'h1);
        chk("dir_trap_pc", trap_pc_o, 32'h100);
        rd("dir_mepc", 12'h341, 32'h40);
        rd("dir_mcause", 12'h342, 32'h8000_000B);
        rd("dir_mstatus", 12'h300, 32'h80);
        step();
        chk("dir_pulse_end", {31'd0, trap_taken_o}, 32'h0);

        // Return, then the still-pending interrupt is retaken
        is_mret_i = 1'b1;
        step();
        is_mret_i = 1'b0;
        chk("ret_pulse", {31'd0, mret_taken_o}, 32'h1);
        chk("ret_pc", trap_pc_o, 32'h40);
        rd("ret_mstatus", 12'h300, 32'h88);
        step();
        chk("ret_pulse_end", {31'd0, mret_taken_o}, 32'h0);
        instr_valid_i = 1'b1;
        pc_i = 32'h80;
        step();
        instr_valid_i = 1'b0;
        chk("retake_pulse", {31'd0, trap_taken_o}, 32'h1);
        rd("retake_mepc", 12'h341, 32'h80);
        step();

        // Collision: software mstatus write in the trap-entry cycle loses
        wr(12'h300, 32'h0000_0008);
        csr_we_i = 1'b1;
        csr_addr_w_i = 12'h300;
        csr_data_i = 32'h8;
        instr_valid_i = 1'b1;
        pc_i = 32'h44;
        step();
        csr_we_i = 1'b0;
        instr_valid_i = 1'b0;
        chk("coll_pulse", {31'd0, trap_taken_o}, 32'h1);
        rd("coll_mstatus", 12'h300, 32'h80);
        ext_irq_i = 1'b0;
        step();
        step();
        rd("mip_clear", 12'h344, 32'h0);

        // Vectored priority
        wr(12'h305, 32'h0000_0201);
        wr(12'h304, 32'h0003_0000);
        wr(12'h300, 32'h0000_0008);
        irq_i = 4'b0011;
        step();
        instr_valid_i = 1'b1;
        pc_i = 32'h100;
        step();
        instr_valid_i = 1'b0;
        chk("vec_pulse", {31'd0, trap_taken_o}, 32'h1);
        chk("vec_pc", trap_pc_o, 32'h240);
        rd("vec_mcause", 12'h342, 32'h8000_0010);
        rd("vec_mtvec", 12'h305, 32'h201);
        irq_i = 4'b0000;
        step();

        // Masking: global disable, then per-line disable
        wr(12'h304, 32'h0000_0800);
        wr(12'h300, 32'h0000_0000);
        ext_irq_i = 1'b1;
        instr_valid_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (trap_taken_o) pulses++;
        end
        chk("mask_mstatus", pulses, 32'd0);
        instr_valid_i = 1'b0;
        wr(12'h304, 32'h0000_0000);
        wr(12'h300, 32'h0000_0008);
        instr_valid_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (trap_taken_o) pulses++;
        end
        chk("mask_mie", pulses, 32'd0);
        rd("mask_mip", 12'h344, 32'h0000_0800);
        instr_valid_i = 1'b0;

        // Cycle counter
`ifdef CSR_MCYCLE_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_lo_wr", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_hi_before", 12'hB80, 32'h0);
        step();
        rd("mcycle_hi_carry", 12'hB80, 32'h1);
        rd("mcycle_lo_wrap", 12'hB00, 32'h0);
`else
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_off_lo", 12'hB00, 32'h0);
        rd("mcycle_off_hi", 12'hB80, 32'h0);
`endif

        // Reset during TAKE drops the pulse at once
        wr(12'h304, 32'h0000_0800);
        instr_valid_i = 1'b1;
        pc_i = 32'h60;
        step();
        instr_valid_i = 1'b0;
        chk("pre_rst_pulse", {31'd0, trap_taken_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_take", {31'd0, trap_taken_o}, 32'h0);
        rd("rst_mid_mtvec", 12'h305, 32'h0);
        ext_irq_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
